// File: rtl/led_matrix_scan.sv
// -----------------------------------------------------------------------------
// led_matrix_scan
//
// Row-multiplexed driver for an 8x8 LED matrix. A 64-bit glyph bitmap is
// captured into a shadow buffer on a write strobe. It is promoted to the
// active (displayed) buffer only at a frame boundary, so a glyph change never
// tears mid-scan. Each row period lasts ROW_CYCLES clocks. The first
// BLANK_CYCLES of each period are dark, which stops ghosting while the row
// drivers switch.
//
// Parameters
//   ROW_CYCLES    clk cycles per row period (must be >= BLANK_CYCLES+1)
//   BLANK_CYCLES  dark cycles at the start of each row period
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-high reset
//   frame_in    in   64  bitmap; row r = frame_in[8r+7:8r], bit 8r+c = column c
//   frame_wr    in   1   1-cycle strobe: capture frame_in into the shadow buffer
//   bright      in   5   brightness 0..16, >16 saturates (dimming build only)
//   row_sel     out  8   one-hot row drive, bit r = row r lit
//   col         out  8   column data for the lit row (1 = LED on)
//   frame_done  out  1   1-cycle pulse when the row 7 period ends
//   pending     out  1   shadow holds a frame that is not yet displayed
//
// Build option
//   LED_SCAN_DIMMING_EN  when defined, adds the `bright` input. The lit window
//                        of each row shrinks to (ON_SPAN*bright)>>4 cycles,
//                        where ON_SPAN = ROW_CYCLES-BLANK_CYCLES. `bright` is
//                        sampled only at frame boundaries and resets to 16.
//                        When undefined, every row is lit for the whole span
//                        after blanking.
// -----------------------------------------------------------------------------
module led_matrix_scan #(
  parameter int ROW_CYCLES   = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] frame_in,
  input  logic        frame_wr,
`ifdef LED_SCAN_DIMMING_EN
  input  logic [4:0]  bright,
`endif
  output logic [7:0]  row_sel,
  output logic [7:0]  col,
  output logic        frame_done,
  output logic        pending
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       ROW_LAST  = 3'd7;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;         // position inside the current row period
  logic [2:0]       r_row_idx;     // row currently being scanned
  logic [63:0]      r_active;      // frame being displayed
  logic [63:0]      r_shadow;      // most recently written frame
  logic             r_pending;     // shadow not yet promoted to active
  logic [7:0]       r_row_sel;
  logic [7:0]       r_col;
  logic             r_frame_done;

  // ---------------------------------------------------------------------------
  // Scan position decode
  // ---------------------------------------------------------------------------
  logic       w_row_end;     // last cycle of the current row period
  logic       w_frame_end;   // last cycle of row 7: the frame boundary
  logic       w_past_blank;  // blanking interval of this row is over
  logic       w_lit;         // row drivers enabled this cycle
  logic [7:0] w_row_onehot;
  logic [7:0] w_col_row;

  assign w_row_end    = (r_cnt == CNT_LAST);
  assign w_frame_end  = w_row_end && (r_row_idx == ROW_LAST);
  assign w_past_blank = (r_cnt >= CNT_BLANK);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_row_onehot            = 8'd0;
    w_row_onehot[r_row_idx] = 1'b1;
  end

  // Row r occupies bits [8r+7:8r] of the frame.
  assign w_col_row = r_active[{r_row_idx, 3'b000} +: 8];

`ifdef LED_SCAN_DIMMING_EN
  // ---------------------------------------------------------------------------
  // Dimming: the lit window after blanking is scaled by bright/16.
  // ---------------------------------------------------------------------------
  localparam int ON_SPAN = ROW_CYCLES - BLANK_CYCLES;
  // ON_SPAN can equal 2**CNT_W when BLANK_CYCLES is 0, so it gets an extra
  // bit. The product with a 5-bit brightness then needs 5 more.
  localparam int LW = CNT_W + 6;
  localparam logic [LW-1:0] ON_SPAN_L = LW'(ON_SPAN);

  logic [4:0]    r_bright;          // brightness in force for this frame
  logic [4:0]    w_bright_clamped;
  logic [LW-1:0] w_on_limit;        // lit cycles per row at r_bright
  logic [LW-1:0] w_on_pos;          // cycles elapsed since blanking ended

  assign w_bright_clamped = (bright > 5'd16) ? 5'd16 : bright;
  assign w_on_limit       = (ON_SPAN_L * LW'(r_bright)) >> 4;
  // Only meaningful when w_past_blank is set; it wraps harmlessly otherwise.
  assign w_on_pos         = LW'(r_cnt - CNT_BLANK);
  assign w_lit            = w_past_blank && (w_on_pos < w_on_limit);

  // Sampling only at the frame boundary keeps every row of a frame at the
  // same brightness. A mid-frame change would show as a visible band.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright <= 5'd16;
    end else if (w_frame_end) begin
      r_bright <= w_bright_clamped;
    end
  end
`else
  assign w_lit = w_past_blank;
`endif

  // ---------------------------------------------------------------------------
  // Row timing: cnt counts 0..ROW_CYCLES-1, then advances the row (7 wraps to 0).
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the always_ff blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_row_idx <= 3'd0;
    end else if (w_row_end) begin
      r_cnt     <= '0;
      r_row_idx <= r_row_idx + 3'd1;
    end else begin
      r_cnt     <= r_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer
  //   - A write always lands in the shadow and marks it pending. The last
  //     write before a boundary wins.
  //   - At the boundary a pending shadow is promoted. The promotion reads the
  //     pre-edge shadow. A write on the boundary cycle therefore shows the
  //     older frame now, and its own data stays pending for the next frame.
  // ---------------------------------------------------------------------------
  // NOTE: both buffers are plain flops, not RAM. They are reset so the matrix
  // shows a defined blank frame after reset, and so a frame pending at reset
  // is really discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= 64'd0;
      r_shadow  <= 64'd0;
      r_pending <= 1'b0;
    end else begin
      if (frame_wr) begin
        r_shadow <= frame_in;
      end
      if (w_frame_end && r_pending) begin
        r_active <= r_shadow;
      end
      if (frame_wr) begin
        r_pending <= 1'b1;
      end else if (w_frame_end) begin
        r_pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, one cycle behind {cnt,row_idx,active}. Registering the
  // drivers gives the pads clean, glitch-free edges. Column data is forced to
  // zero whenever no row is driven.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_sel    <= 8'd0;
      r_col        <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_row_sel    <= w_lit ? w_row_onehot : 8'd0;
      r_col        <= w_lit ? w_col_row    : 8'd0;
      r_frame_done <= w_frame_end;
    end
  end

  assign row_sel    = r_row_sel;
  assign col        = r_col;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

// File: tb/tb_led_matrix_scan.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scan
//
// Directed bench for led_matrix_scan with ROW_CYCLES=8 and BLANK_CYCLES=2, so
// one frame is 64 clocks. Every clock passes through tick(). tick() checks that
// row_sel is one-hot or zero and that col is zero whenever no row is driven. It
// also compares all outputs against a small reference of the scan and the
// double buffer. The scenario tasks add hand-computed checks at specific scan
// positions. Define LED_SCAN_DIMMING_EN to also exercise brightness control.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_matrix_scan;

  localparam int ROW_CYCLES   = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME_CYCLES = 8 * ROW_CYCLES;
  localparam int WAIT_LIMIT   = FRAME_CYCLES + 16;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [63:0] frame_in = 64'd0;
  logic        frame_wr = 1'b0;
`ifdef LED_SCAN_DIMMING_EN
  logic [4:0]  bright   = 5'd16;
`endif
  logic [7:0]  row_sel;
  logic [7:0]  col;
  logic        frame_done;
  logic        pending;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: clocks since reset release, lit cycles per row, buffers.
  int          k         = 0;
  int          lit_n     = ROW_CYCLES - BLANK_CYCLES;
  logic [63:0] m_active  = 64'd0;
  logic [63:0] m_shadow  = 64'd0;
  logic        m_pending = 1'b0;

  led_matrix_scan #(
    .ROW_CYCLES   (ROW_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_in   (frame_in),
    .frame_wr   (frame_wr),
`ifdef LED_SCAN_DIMMING_EN
    .bright     (bright),
`endif
    .row_sel    (row_sel),
    .col        (col),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

`ifdef LED_SCAN_DIMMING_EN
  function automatic int lit_for(input logic [4:0] b);
    int bb;
    bb = (b > 5'd16) ? 16 : int'(b);
    return ((ROW_CYCLES - BLANK_CYCLES) * bb) >> 4;
  endfunction
`endif

  // One clock. Outputs are sampled 1 ns after the rising edge. Expected values
  // come from the reference state as it stood before that edge.
  task automatic tick();
    int         pos;
    int         r;
    int         c;
    logic       lit;
    logic       bnd;
    logic [7:0] e_rs;
    logic [7:0] e_col;
    logic       e_fd;
    @(posedge clk);
    #1;
    if (rst) begin
      k         = 0;
      lit_n     = ROW_CYCLES - BLANK_CYCLES;
      m_active  = 64'd0;
      m_shadow  = 64'd0;
      m_pending = 1'b0;
      e_rs      = 8'd0;
      e_col     = 8'd0;
      e_fd      = 1'b0;
    end else begin
      k++;
      pos   = (k - 1) % FRAME_CYCLES;
      r     = pos / ROW_CYCLES;
      c     = pos % ROW_CYCLES;
      lit   = (c >= BLANK_CYCLES) && ((c - BLANK_CYCLES) < lit_n);
      e_rs  = lit ? 8'(1 << r) : 8'd0;
      e_col = lit ? m_active[8*r +: 8] : 8'd0;
      bnd   = (pos == FRAME_CYCLES - 1);
      e_fd  = bnd;
      if (bnd && m_pending) m_active = m_shadow;
      if (frame_wr) m_shadow = frame_in;
      if (frame_wr) m_pending = 1'b1;
      else if (bnd) m_pending = 1'b0;
`ifdef LED_SCAN_DIMMING_EN
      if (bnd) lit_n = lit_for(bright);
`endif
    end
    n_cmp++;
    if (!$onehot0(row_sel) || (row_sel == 8'd0 && col != 8'd0)) begin
      n_bad++;
      $display("FAIL invariant k=%0d row_sel=%h col=%h (want one-hot/zero, col=0 when dark)", k, row_sel, col);
    end
    n_cmp++;
    if (row_sel !== e_rs) begin
      n_bad++;
      $display("FAIL row_sel k=%0d got %h expected %h", k, row_sel, e_rs);
    end
    n_cmp++;
    if (col !== e_col) begin
      n_bad++;
      $display("FAIL col k=%0d got %h expected %h", k, col, e_col);
    end
    n_cmp++;
    if (frame_done !== e_fd) begin
      n_bad++;
      $display("FAIL frame_done k=%0d got %b expected %b", k, frame_done, e_fd);
    end
    n_cmp++;
    if (pending !== m_pending) begin
      n_bad++;
      $display("FAIL pending k=%0d got %b expected %b", k, pending, m_pending);
    end
  endtask

  // Advance until the outputs show row r, cnt c.
  task automatic goto_pos(input int r, input int c);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((k == 0 || ((k - 1) % FRAME_CYCLES) != (ROW_CYCLES * r + c)) && n < WAIT_LIMIT);
    if (k == 0 || ((k - 1) % FRAME_CYCLES) != (ROW_CYCLES * r + c)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL goto_pos timeout row=%0d cnt=%0d", r, c);
    end
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < WAIT_LIMIT);
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_done_wait got %b expected 1 within %0d cycles", frame_done, WAIT_LIMIT);
    end
  endtask

  task automatic write_frame(input logic [63:0] f);
    frame_in = f;
    frame_wr = 1'b1;
    tick();
    frame_wr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({row_sel, col, frame_done, pending} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h expected 0", {row_sel, col, frame_done, pending});
    end
    rst = 1'b0;
  endtask

  // Blank frame: each row lit 6 cycles in turn, frame_done every 64 cycles.
  task automatic test_scan_blank();
    int lit3;
    int fd;
    lit3 = 0;
    fd   = 0;
    repeat (130) begin
      tick();
      if (row_sel == 8'h08) lit3++;
      if (frame_done) fd++;
    end
    n_cmp++;
    if (lit3 !== 12) begin
      n_bad++;
      $display("FAIL row3_lit_cycles got %0d expected 12", lit3);
    end
    n_cmp++;
    if (fd !== 2) begin
      n_bad++;
      $display("FAIL frame_done_count got %0d expected 2", fd);
    end
  endtask

  task automatic test_frame_load();
    logic [7:0] exp_rows [8] = '{8'h7E, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h7E, 8'h00};
    logic [7:0] exp_sel  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    goto_pos(3, 0);
    write_frame(64'h00_7E_81_81_81_81_81_7E);
    n_cmp++;
    if (pending !== 1'b1) begin
      n_bad++;
      $display("FAIL load_pending_set got %b expected 1", pending);
    end
    wait_frame_done();
    n_cmp++;
    if (pending !== 1'b0) begin
      n_bad++;
      $display("FAIL load_pending_clear got %b expected 0", pending);
    end
    for (int r = 0; r < 8; r++) begin
      goto_pos(r, 4);
      n_cmp++;
      if (row_sel !== exp_sel[r] || col !== exp_rows[r]) begin
        n_bad++;
        $display("FAIL load_row%0d got sel=%h col=%h expected sel=%h col=%h", r, row_sel, col, exp_sel[r], exp_rows[r]);
      end
    end
  endtask

  // A then B in one frame (B wins), then C written on the boundary cycle.
  task automatic test_back_to_back();
    logic [7:0] b_rows [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] c_rows [8] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    goto_pos(2, 0);
    write_frame(64'h5555_5555_5555_5555);
    goto_pos(5, 0);
    write_frame(64'h01_02_04_08_10_20_40_80);
    goto_pos(7, 6);
    write_frame(64'hFF00_FF00_FF00_FF00);
    n_cmp++;
    if (frame_done !== 1'b1 || pending !== 1'b1) begin
      n_bad++;
      $display("FAIL boundary_write got fd=%b pending=%b expected fd=1 pending=1", frame_done, pending);
    end
    for (int r = 0; r < 8; r++) begin
      goto_pos(r, 5);
      n_cmp++;
      if (col !== b_rows[r]) begin
        n_bad++;
        $display("FAIL b2b_B_row%0d got %h expected %h", r, col, b_rows[r]);
      end
    end
    wait_frame_done();
    n_cmp++;
    if (pending !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_pending_clear got %b expected 0", pending);
    end
    for (int r = 0; r < 8; r++) begin
      goto_pos(r, 3);
      n_cmp++;
      if (col !== c_rows[r]) begin
        n_bad++;
        $display("FAIL b2b_C_row%0d got %h expected %h", r, col, c_rows[r]);
      end
    end
  endtask

  // Reset in the middle of row 4 with a frame still pending.
  task automatic test_reset_mid();
    goto_pos(1, 0);
    write_frame(64'hFFFF_FFFF_FFFF_FFFF);
    n_cmp++;
    if (pending !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pending_set got %b expected 1", pending);
    end
    goto_pos(4, 4);
    n_cmp++;
    if (row_sel !== 8'h10) begin
      n_bad++;
      $display("FAIL mid_row4_lit got %h expected 10", row_sel);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({row_sel, col, frame_done, pending} !== 18'd0) begin
      n_bad++;
      $display("FAIL async_reset got %h expected 0", {row_sel, col, frame_done, pending});
    end
    repeat (2) tick();
    rst = 1'b0;
    goto_pos(0, 4);
    n_cmp++;
    if (row_sel !== 8'h01 || col !== 8'h00 || pending !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_row0 got sel=%h col=%h pending=%b expected 01/00/0", row_sel, col, pending);
    end
    wait_frame_done();
    goto_pos(1, 4);
    n_cmp++;
    if (row_sel !== 8'h02 || col !== 8'h00) begin
      n_bad++;
      $display("FAIL lost_frame_row1 got sel=%h col=%h expected 02/00", row_sel, col);
    end
  endtask

`ifdef LED_SCAN_DIMMING_EN
  task automatic test_dimming();
    bright = 5'd8;
    wait_frame_done();
    goto_pos(3, 4);
    n_cmp++;
    if (row_sel !== 8'h08) begin
      n_bad++;
      $display("FAIL dim8_cnt4 got %h expected 08", row_sel);
    end
    goto_pos(3, 5);
    n_cmp++;
    if (row_sel !== 8'h00) begin
      n_bad++;
      $display("FAIL dim8_cnt5 got %h expected 00", row_sel);
    end
    bright = 5'd0;
    wait_frame_done();
    goto_pos(3, 2);
    n_cmp++;
    if (row_sel !== 8'h00) begin
      n_bad++;
      $display("FAIL dim0_dark got %h expected 00", row_sel);
    end
    wait_frame_done();
    bright = 5'd31;
    wait_frame_done();
    goto_pos(3, 7);
    n_cmp++;
    if (row_sel !== 8'h08) begin
      n_bad++;
      $display("FAIL dim31_cnt7 got %h expected 08", row_sel);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_scan_blank();
    test_frame_load();
    test_back_to_back();
    test_reset_mid();
`ifdef LED_SCAN_DIMMING_EN
    test_dimming();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
